// File: rtl/mem_arbiter_if.sv
// Split-transaction memory port: req/addr_ok accepts a request,
// data_ok/rdata returns its response.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              req;
  logic              write;
  logic [XLEN/8-1:0] wstrb;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [XLEN-1:0]   rdata;

  // Side that issues requests.
  modport master (
    output req, write, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  // Side that accepts requests and returns responses.
  modport slave (
    input  req, write, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction-fetch and data masters.
// Responses are routed back in acceptance order through a small FIFO of
// source IDs, and a streak counter bounds how long a waiting fetch can
// be starved by back-to-back data grants.
module mem_arbiter #(
  parameter int XLEN        = 32,
  parameter int OUTSTANDING = 2,
  parameter int D_STREAK    = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   iram,
  mem_arbiter_if.slave   dram,
  mem_arbiter_if.master  mem
);

  localparam int ST_W  = $clog2(D_STREAK + 1);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  logic [ST_W-1:0]        streak;
  logic [OUTSTANDING-1:0] id_fifo;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic full;
  logic empty;
  logic grant_d;
  logic mem_req;
  logic accept;
  logic pop;
  logic head_d;

  assign full  = (count == CNT_W'(OUTSTANDING));
  assign empty = (count == '0);

  // Data wins unless a fetch is waiting and data has used up its streak.
  assign grant_d = dram.req & (~iram.req | (streak < ST_W'(D_STREAK)));
  assign mem_req = (iram.req | dram.req) & ~full;
  assign accept  = mem_req & mem.addr_ok;
  // A response with nothing outstanding belongs to a request abandoned by reset.
  assign pop     = mem.data_ok & ~empty;
  assign head_d  = id_fifo[rd_ptr];

  assign mem.req   = mem_req;
  assign mem.write = mem_req & (grant_d ? dram.write : iram.write);
  assign mem.wstrb = mem_req ? (grant_d ? dram.wstrb : iram.wstrb) : '0;
  assign mem.addr  = mem_req ? (grant_d ? dram.addr  : iram.addr)  : '0;
  assign mem.wdata = mem_req ? (grant_d ? dram.wdata : iram.wdata) : '0;

  assign iram.addr_ok = mem.addr_ok & mem_req & ~grant_d;
  assign dram.addr_ok = mem.addr_ok & mem_req &  grant_d;

  assign iram.data_ok = pop & ~head_d;
  assign dram.data_ok = pop &  head_d;
  assign iram.rdata   = mem.rdata;
  assign dram.rdata   = mem.rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Source-ID FIFO: push the granted master on acceptance, pop on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        id_fifo[wr_ptr] <= grant_d;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Consecutive data grants taken while a fetch is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (!iram.req) begin
      streak <= '0;
    end else if (accept && !grant_d) begin
      streak <= '0;
    end else if (accept && grant_d && (streak < ST_W'(D_STREAK))) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with OUTSTANDING=2, D_STREAK=4.
module tb_mem_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.XLEN(XLEN)) iram_bus ();
  mem_arbiter_if #(.XLEN(XLEN)) dram_bus ();
  mem_arbiter_if #(.XLEN(XLEN)) mem_bus ();

  mem_arbiter #(.XLEN(XLEN), .OUTSTANDING(2), .D_STREAK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .iram (iram_bus.slave),
    .dram (dram_bus.slave),
    .mem  (mem_bus.master)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    iram_bus.req = 0; iram_bus.write = 0; iram_bus.wstrb = 0; iram_bus.addr = 0; iram_bus.wdata = 0;
    dram_bus.req = 0; dram_bus.write = 0; dram_bus.wstrb = 0; dram_bus.addr = 0; dram_bus.wdata = 0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = 0;
  endtask

  // Inputs change 1 unit after the edge; checks run 3 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    mem_bus.rdata = 32'h1234_5678;
    next_cycle();
    mem_bus.data_ok = 1;
    settle();
    total++; if (mem_bus.req !== 1'b0) begin bad++; $display("FAIL reset mem_req got=%b want=0", mem_bus.req); end
    total++; if ({iram_bus.addr_ok, dram_bus.addr_ok} !== 2'b00) begin bad++; $display("FAIL reset addr_ok got=%b want=00", {iram_bus.addr_ok, dram_bus.addr_ok}); end
    total++; if ({iram_bus.data_ok, dram_bus.data_ok} !== 2'b00) begin bad++; $display("FAIL reset data_ok got=%b want=00", {iram_bus.data_ok, dram_bus.data_ok}); end
    total++; if ({mem_bus.write, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata} !== '0) begin bad++; $display("FAIL reset mem_payload got=%h want=0", {mem_bus.write, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata}); end
    total++; if (iram_bus.rdata !== 32'h1234_5678 || dram_bus.rdata !== 32'h1234_5678) begin bad++; $display("FAIL reset rdata got=%h/%h want=12345678", iram_bus.rdata, dram_bus.rdata); end
    next_cycle();
    rst = 0;
    mem_bus.data_ok = 0;
    next_cycle();
    settle();
    total++; if (mem_bus.req !== 1'b0 || {iram_bus.addr_ok, dram_bus.addr_ok} !== 2'b00) begin bad++; $display("FAIL post_reset idle got req=%b aok=%b want 0/00", mem_bus.req, {iram_bus.addr_ok, dram_bus.addr_ok}); end
    total++; if (dut.count !== '0) begin bad++; $display("FAIL post_reset count got=%0d want=0", dut.count); end
  endtask

  task automatic test_i_only();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      iram_bus.req     = (k < 3);
      iram_bus.addr    = (k < 3) ? 32'(4 * k) : 32'h0;
      mem_bus.addr_ok  = 1;
      mem_bus.data_ok  = (k >= 1);
      mem_bus.rdata    = 32'hA000_0000 + 32'(k);
      settle();
      if (k < 3) begin
        total++; if (iram_bus.addr_ok !== 1'b1 || mem_bus.addr !== 32'(4 * k)) begin bad++; $display("FAIL i_only accept cyc=%0d got aok=%b addr=%h want 1/%h", k, iram_bus.addr_ok, mem_bus.addr, 4 * k); end
      end
      if (k >= 1) begin
        total++; if (iram_bus.data_ok !== 1'b1 || iram_bus.rdata !== 32'hA000_0000 + 32'(k)) begin bad++; $display("FAIL i_only resp cyc=%0d got dok=%b rdata=%h", k, iram_bus.data_ok, iram_bus.rdata); end
      end
      total++; if (dram_bus.data_ok !== 1'b0) begin bad++; $display("FAIL i_only dram_data_ok cyc=%0d got=%b want=0", k, dram_bus.data_ok); end
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_streak();
    logic [9:0] exp_d;
    exp_d = 10'b01111_01111;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      iram_bus.req = 1; iram_bus.addr = 32'h40;
      dram_bus.req = 1; dram_bus.addr = 32'h400;
      mem_bus.addr_ok = 1;
      mem_bus.data_ok = (k > 0);
      settle();
      total++; if ({dram_bus.addr_ok, iram_bus.addr_ok} !== {exp_d[k], ~exp_d[k]}) begin bad++; $display("FAIL streak grant cyc=%0d got d/i=%b want=%b", k, {dram_bus.addr_ok, iram_bus.addr_ok}, {exp_d[k], ~exp_d[k]}); end
      if (k > 0) begin
        total++; if ({dram_bus.data_ok, iram_bus.data_ok} !== {exp_d[k-1], ~exp_d[k-1]}) begin bad++; $display("FAIL streak route cyc=%0d got d/i=%b want=%b", k, {dram_bus.data_ok, iram_bus.data_ok}, {exp_d[k-1], ~exp_d[k-1]}); end
      end
      if (k == 4) begin
        total++; if (dut.streak !== 3'd4) begin bad++; $display("FAIL streak peak got=%0d want=4", dut.streak); end
      end
    end
    next_cycle();
    drive_idle();
    mem_bus.data_ok = 1;
    settle();
    total++; if (iram_bus.data_ok !== 1'b1) begin bad++; $display("FAIL streak last_resp got=%b want=1", iram_bus.data_ok); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_streak_clear();
    logic [7:0] exp_d;
    exp_d = 8'b0111_1111;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      iram_bus.req = (k != 2); iram_bus.addr = 32'h80;
      dram_bus.req = 1;        dram_bus.addr = 32'h800;
      mem_bus.addr_ok = 1;
      mem_bus.data_ok = (k > 0);
      settle();
      total++; if ({dram_bus.addr_ok, iram_bus.addr_ok} !== {exp_d[k], ~exp_d[k]}) begin bad++; $display("FAIL streak_clear grant cyc=%0d got d/i=%b want=%b", k, {dram_bus.addr_ok, iram_bus.addr_ok}, {exp_d[k], ~exp_d[k]}); end
      if (k == 3) begin
        total++; if (dut.streak !== 3'd0) begin bad++; $display("FAIL streak_clear no_ireq got=%0d want=0", dut.streak); end
      end
    end
    next_cycle();
    drive_idle();
    mem_bus.data_ok = 1;
    next_cycle();
    drive_idle();
  endtask

  task automatic test_full();
    logic [4:0] exp_req;
    logic [4:0] exp_dok;
    logic [31:0] addr_q;
    exp_req = 5'b10011;
    exp_dok = 5'b11000;
    addr_q  = 32'h100;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      iram_bus.req  = 1;
      iram_bus.addr = addr_q;
      mem_bus.addr_ok = 1;
      mem_bus.data_ok = (k == 3 || k == 4);
      mem_bus.rdata   = 32'hF000_0000 + 32'(k);
      settle();
      total++; if (mem_bus.req !== exp_req[k] || iram_bus.addr_ok !== exp_req[k]) begin bad++; $display("FAIL full accept cyc=%0d got req=%b aok=%b want=%b", k, mem_bus.req, iram_bus.addr_ok, exp_req[k]); end
      total++; if (iram_bus.data_ok !== exp_dok[k]) begin bad++; $display("FAIL full resp cyc=%0d got=%b want=%b", k, iram_bus.data_ok, exp_dok[k]); end
      if (k == 4) begin
        total++; if (mem_bus.addr !== 32'h108) begin bad++; $display("FAIL full held_addr got=%h want=00000108", mem_bus.addr); end
      end
      if (exp_req[k]) addr_q = addr_q + 32'h4;
    end
    next_cycle(); drive_idle();
    next_cycle(); drive_idle();
    next_cycle(); drive_idle();
    mem_bus.data_ok = 1;
    settle();
    total++; if (iram_bus.data_ok !== 1'b1) begin bad++; $display("FAIL full late_resp got=%b want=1", iram_bus.data_ok); end
    next_cycle(); drive_idle();
    settle();
    total++; if (dut.count !== '0) begin bad++; $display("FAIL full drained count got=%0d want=0", dut.count); end
  endtask

  task automatic test_interleave();
    next_cycle(); drive_idle();
    iram_bus.req = 1; iram_bus.addr = 32'h10; mem_bus.addr_ok = 1;
    settle();
    total++; if (iram_bus.addr_ok !== 1'b1 || mem_bus.addr !== 32'h10) begin bad++; $display("FAIL interleave acc_a got aok=%b addr=%h", iram_bus.addr_ok, mem_bus.addr); end
    next_cycle(); drive_idle();
    dram_bus.req = 1; dram_bus.addr = 32'h200; mem_bus.addr_ok = 1;
    settle();
    total++; if (dram_bus.addr_ok !== 1'b1 || mem_bus.addr !== 32'h200) begin bad++; $display("FAIL interleave acc_b got aok=%b addr=%h", dram_bus.addr_ok, mem_bus.addr); end
    next_cycle(); drive_idle();
    iram_bus.req = 1; iram_bus.addr = 32'h14; mem_bus.addr_ok = 1; mem_bus.data_ok = 1;
    settle();
    total++; if ({iram_bus.data_ok, dram_bus.data_ok, iram_bus.addr_ok} !== 3'b100) begin bad++; $display("FAIL interleave resp_a got i_dok/d_dok/i_aok=%b want=100", {iram_bus.data_ok, dram_bus.data_ok, iram_bus.addr_ok}); end
    next_cycle();
    settle();
    total++; if ({iram_bus.data_ok, dram_bus.data_ok, iram_bus.addr_ok} !== 3'b011) begin bad++; $display("FAIL interleave resp_b got i_dok/d_dok/i_aok=%b want=011", {iram_bus.data_ok, dram_bus.data_ok, iram_bus.addr_ok}); end
    next_cycle(); drive_idle();
    mem_bus.data_ok = 1;
    settle();
    total++; if ({iram_bus.data_ok, dram_bus.data_ok} !== 2'b10) begin bad++; $display("FAIL interleave resp_c got i/d=%b want=10", {iram_bus.data_ok, dram_bus.data_ok}); end
    next_cycle(); drive_idle();
  endtask

  task automatic test_dram_write();
    next_cycle(); drive_idle();
    dram_bus.req = 1; dram_bus.write = 1; dram_bus.wstrb = 4'hF;
    dram_bus.addr = 32'h300; dram_bus.wdata = 32'hDEADBEEF; mem_bus.addr_ok = 1;
    settle();
    total++; if ({mem_bus.write, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata} !== {1'b1, 4'hF, 32'h300, 32'hDEADBEEF} || dram_bus.addr_ok !== 1'b1) begin bad++; $display("FAIL dwrite payload got w=%b s=%h a=%h d=%h aok=%b", mem_bus.write, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata, dram_bus.addr_ok); end
    next_cycle(); drive_idle();
    mem_bus.data_ok = 1;
    settle();
    total++; if ({dram_bus.data_ok, iram_bus.data_ok} !== 2'b10) begin bad++; $display("FAIL dwrite resp got d/i=%b want=10", {dram_bus.data_ok, iram_bus.data_ok}); end
    next_cycle(); drive_idle();
  endtask

  task automatic test_reset_outstanding();
    next_cycle(); drive_idle();
    iram_bus.req = 1; iram_bus.addr = 32'h20; mem_bus.addr_ok = 1;
    next_cycle(); drive_idle();
    iram_bus.req = 1; iram_bus.addr = 32'h24;
    dram_bus.req = 1; dram_bus.addr = 32'h220; mem_bus.addr_ok = 1;
    settle();
    total++; if (dram_bus.addr_ok !== 1'b1) begin bad++; $display("FAIL rst_out d_accept got=%b want=1", dram_bus.addr_ok); end
    next_cycle(); drive_idle();
    rst = 1;
    settle();
    total++; if (dut.streak !== 3'd1 || dut.count !== 2'd2) begin bad++; $display("FAIL rst_out pre_state got streak=%0d count=%0d want 1/2", dut.streak, dut.count); end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); drive_idle();
      rst = 0;
      mem_bus.data_ok = 1;
      settle();
      total++; if ({iram_bus.data_ok, dram_bus.data_ok} !== 2'b00) begin bad++; $display("FAIL rst_out stale cyc=%0d got i/d=%b want=00", k, {iram_bus.data_ok, dram_bus.data_ok}); end
    end
    next_cycle(); drive_idle();
    settle();
    total++; if (dut.count !== '0 || dut.streak !== '0) begin bad++; $display("FAIL rst_out state got count=%0d streak=%0d want 0/0", dut.count, dut.streak); end
    iram_bus.req = 1; iram_bus.addr = 32'h30; mem_bus.addr_ok = 1;
    settle();
    total++; if (iram_bus.addr_ok !== 1'b1) begin bad++; $display("FAIL rst_out reaccept got=%b want=1", iram_bus.addr_ok); end
    next_cycle(); drive_idle();
    mem_bus.data_ok = 1;
    settle();
    total++; if ({iram_bus.data_ok, dram_bus.data_ok} !== 2'b10) begin bad++; $display("FAIL rst_out new_resp got i/d=%b want=10", {iram_bus.data_ok, dram_bus.data_ok}); end
    next_cycle(); drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_i_only();
    test_streak();
    test_streak_clear();
    test_full();
    test_interleave();
    test_dram_write();
    test_reset_outstanding();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
